// File: rtl/shift_reg_4bit.sv
// shift_reg_4bit: serial-in / parallel-out left-shift register.
// Each bit has its own asynchronous clear and preset. The reset is
// asynchronous and active-low. The priority, highest first, is:
// rst_n, clr[i], set[i], then the shift.
module shift_reg_4bit #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] set,
    output logic [WIDTH-1:0] out
);

    // Each bit is a separate flop, because each bit has its own async controls.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic bit_reg;
            logic bit_next;

            // Bit 0 takes the serial input. Higher bits take the value of
            // their lower neighbour from before the edge.
            if (gi == 0) begin : g_first
                assign bit_next = in;
            end else begin : g_rest
                assign bit_next = out[gi-1];
            end

            // Per-bit flop. Reset wins over clear, and clear wins over preset.
            always_ff @(posedge clk or negedge rst_n or posedge clr[gi] or posedge set[gi]) begin
                if (!rst_n) begin
                    bit_reg <= RESET_VAL[gi];
                end else if (clr[gi]) begin
                    bit_reg <= 1'b0;
                end else if (set[gi]) begin
                    bit_reg <= 1'b1;
                end else begin
                    bit_reg <= bit_next;
                end
            end

            assign out[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: tb/tb_shift_reg_4bit.sv
// Self-checking bench for shift_reg_4bit.
// The reference model holds the register contents as a plain 4-bit value.
// On each clock edge it shifts left and ORs in the serial bit.
// Whenever clr or set changes, the bench applies the overrides to the model
// straight away, mirroring the asynchronous clear and preset.
module tb_shift_reg_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in;
    logic [W-1:0] clr;
    logic [W-1:0] set;
    logic [W-1:0] out;

    logic [W-1:0] model;
    int           n_cmp;
    int           n_bad;

    shift_reg_4bit #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .clr   (clr),
        .set   (set),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update on the clock: shift, then apply the per-bit forces.
    always @(posedge clk) begin
        if (!rst_n)
            model = 4'b0000;
        else
            model = ((((model << 1) | {3'b000, in}) | set) & ~clr) & 4'hF;
    end

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (out !== model) begin
            n_bad = n_bad + 1;
            $display("FAIL cycle_model t=%0t out=%b expected=%b", $time, out, model);
        end else begin
            $display("cycle t=%0t in=%b clr=%b set=%b out=%b", $time, in, clr, set, out);
        end
    end

    // Literal check that pins both the DUT and the model.
    task automatic check(input string name, input logic [W-1:0] exp);
        n_cmp = n_cmp + 1;
        if (out !== exp || model !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s out=%b model=%b expected=%b", name, out, model, exp);
        end else begin
            $display("check %s out=%b", name, out);
        end
    endtask

    // Apply an asynchronous change of clr or set, mid-cycle.
    task automatic force_bits(input logic [W-1:0] c, input logic [W-1:0] s);
        clr = c;
        set = s;
        #1;
        if (rst_n) model = ((model | set) & ~clr) & 4'hF;
    endtask

    // Advance past one rising edge, to just after it.
    task automatic edge_step(input logic d);
        in = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model = 4'b0000;
        rst_n = 1'b0;
        in    = 1'b1;
        clr   = 4'b0000;
        set   = 4'b1111;

        // Reset dominates set and in while the clock runs.
        #1 check("reset_hold", 4'b0000);
        repeat (3) begin
            @(posedge clk);
            #2 check("reset_during_clk", 4'b0000);
        end
        rst_n = 1'b1;
        #1 check("reset_release", 4'b0000);
        force_bits(4'b0000, 4'b0000);
        check("after_release_preedge", 4'b0000);
        edge_step(1'b0);
        check("first_edge_zero", 4'b0000);

        // Serial shift of 1,0,1,1.
        edge_step(1'b1); check("shift1", 4'b0001);
        edge_step(1'b0); check("shift2", 4'b0010);
        edge_step(1'b1); check("shift3", 4'b0101);
        edge_step(1'b1); check("shift4", 4'b1011);

        // Asynchronous clear.
        force_bits(4'b1111, 4'b0000);
        check("clr_immediate", 4'b0000);
        edge_step(1'b1); check("clr_hold1", 4'b0000);
        edge_step(1'b1); check("clr_hold2", 4'b0000);
        force_bits(4'b0000, 4'b0000);
        check("clr_release_hold", 4'b0000);
        edge_step(1'b0); check("clr_resume", 4'b0000);

        // Asynchronous preset.
        force_bits(4'b0000, 4'b1111);
        check("set_immediate", 4'b1111);
        edge_step(1'b0); check("set_hold", 4'b1111);
        force_bits(4'b0000, 4'b0000);
        check("set_release_hold", 4'b1111);
        edge_step(1'b0); check("set_resume", 4'b1110);

        // Per-bit control, and clear winning over preset.
        in = 1'b1;
        force_bits(4'b0100, 4'b0100);
        check("conflict_immediate", 4'b1010);
        edge_step(1'b1); check("conflict_edge1", 4'b0001);
        edge_step(1'b0); check("conflict_edge2", 4'b0010);
        force_bits(4'b0001, 4'b0000);
        check("clr0_immediate", 4'b0010);
        edge_step(1'b1); check("clr0_edge", 4'b0100);
        force_bits(4'b0000, 4'b0000);

        // Reset asserted mid-operation aborts the shift at once.
        edge_step(1'b1); check("pre_reset", 4'b1001);
        rst_n = 1'b0;
        #1 model = 4'b0000;
        check("midop_reset", 4'b0000);
        rst_n = 1'b1;
        #1 check("midop_release", 4'b0000);

        // Latency of a single-cycle pulse.
        edge_step(1'b1); check("lat1", 4'b0001);
        edge_step(1'b0); check("lat2", 4'b0010);
        edge_step(1'b0); check("lat3", 4'b0100);
        edge_step(1'b0); check("lat4", 4'b1000);
        edge_step(1'b0); check("lat5", 4'b0000);

        // A few more directed cycles, checked by the model only.
        edge_step(1'b1);
        edge_step(1'b1);
        force_bits(4'b0000, 4'b1000);
        edge_step(1'b0);
        force_bits(4'b0010, 4'b0000);
        edge_step(1'b1);
        force_bits(4'b0000, 4'b0000);
        edge_step(1'b0);
        edge_step(1'b1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_reg_4bit.md
SHIFT_REG_4BIT -- requirements
Module: shift_reg_4bit

Interface
REQ-001 Parameter WIDTH, default 4, register length in bits; all vector ports SHALL be WIDTH wide.
REQ-002 Parameter RESET_VAL, default 4'b0000, value loaded by rst_n; SHALL be WIDTH bits.
REQ-003 clk  input  1  single clock; all shifting SHALL occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low global reset.
REQ-005 in  input  1  serial data input.
REQ-006 clr  input  WIDTH  per-bit asynchronous clear, active-high; clr[i] forces out[i] to 0.
REQ-007 set  input  WIDTH  per-bit asynchronous preset, active-high; set[i] forces out[i] to 1.
REQ-008 out  output  WIDTH  parallel register contents, driven directly from flops with no combinational path from in.

Function
REQ-009 On each rising clk edge with no override active, the block SHALL shift left: out[0] <= in and out[i] <= out[i-1] for i = 1..WIDTH-1; out[WIDTH-1] is discarded.
REQ-010 Serial latency SHALL be 1 clock from in to out[0] and WIDTH clocks from in to out[WIDTH-1].
REQ-011 Bit i SHALL have this override priority, highest first: rst_n low, then clr[i] high, then set[i] high, then the shift.
REQ-012 While clr[i] is high and rst_n is high, out[i] SHALL be 0 immediately, without waiting for a clk edge, and SHALL stay 0 across clk edges.
REQ-013 While set[i] is high, clr[i] is low and rst_n is high, out[i] SHALL be 1 immediately and SHALL stay 1 across clk edges.
REQ-014 clr and set SHALL act per bit; bits with no override active SHALL keep shifting normally, taking data from their lower neighbour's value before the edge.
REQ-015 When an override is released, out[i] SHALL hold its forced value until the next rising clk edge, then resume shifting.
REQ-016 If clr[i] and set[i] are both high, clr SHALL win and out[i] SHALL be 0.
REQ-017 No enable or parallel load exists; the register SHALL shift on every clock edge unless an override is active.

Reset
REQ-018 While rst_n is low, out SHALL equal RESET_VAL (4'b0000) asynchronously, regardless of clk, in, clr and set.
REQ-019 On rst_n deassertion, out SHALL hold RESET_VAL until the first rising clk edge after deassertion.
REQ-020 If rst_n is asserted mid-operation, the shift SHALL abort immediately, out SHALL go to RESET_VAL, and no partial shift SHALL remain afterwards.

Verification
REQ-021 Reset: pulse rst_n low with in=1 and set=4'b1111 while clk toggles -> out=4'b0000 throughout the pulse and until the first rising edge after release.
REQ-022 Serial shift: starting from out=4'b0000, apply in=1,0,1,1 on four successive rising edges -> out=4'b0001, 4'b0010, 4'b0101, 4'b1011.
REQ-023 Asynchronous clear: with out=4'b1011, raise clr=4'b1111 between clk edges -> out=4'b0000 before the next edge, and it stays 0000 while in=1 is clocked.
REQ-024 Asynchronous preset: raise set=4'b1111 with clr=0 mid-cycle -> out=4'b1111 immediately, holding across edges; after release with in=0, one edge -> out=4'b1110.
REQ-025 Per-bit and conflict: set=4'b0100 with clr=4'b0100 -> out[2]=0 while the other bits shift; clr=4'b0001 alone -> out[0]=0 while out[3:1] shift.
REQ-026 Latency: a single-cycle in=1 pulse into out=0 -> it appears on out[0], out[1], out[2], out[3] on edges 1-4, and out=4'b0000 after edge 5.
